// File: rtl/led_pkg.sv
// Shared constants for the LED pattern generator family.
// Mode encodings are the per-channel 2-bit field values on the mode bus.
// Combinational only; no latency or backpressure.
package led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  // Width of the blink half-period input and of the blink timer.
  localparam int BLINK_W = 16;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-clk tick at TICK_HZ from a CLK_HZ clock.
// Latency: first tick is the CLK_HZ/TICK_HZ-th clk after reset release; tick is registered.
// Backpressure: none, free-running.
module tick_gen #(
  parameter int CLK_HZ  = 27000000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1; tick is high for the clk in which the counter has just wrapped to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel off / steady PWM / blink / breathe.
// Latency: led is registered, one clk after the PWM compare.
// Backpressure: none; mode, level and blink_half are sampled every clk.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int TICK_HZ    = 1000,
  parameter int CHANNELS   = 6,
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [PWM_BITS-1:0]     level,
  input  logic [BLINK_W-1:0]      blink_half,
  output logic [CHANNELS-1:0]     led,
  output logic                    tick
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};
  localparam logic                POL     = (ACTIVE_LOW != 0);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] breath_lvl;
  logic                breath_up;
  logic [BLINK_W-1:0]  blink_timer;
  logic [BLINK_W-1:0]  blink_lim;
  logic                blink_phase;
  logic [CHANNELS-1:0] raw;

  // All-ones duty means fully on so full brightness has no dark slot per frame.
  function automatic logic pwm_on(input logic [PWM_BITS-1:0] d,
                                  input logic [PWM_BITS-1:0] c);
    return (d == PWM_MAX) || (c < d);
  endfunction

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Free-running PWM frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Half-period of 0 behaves as 1 tick.
  always_comb begin
    blink_lim = blink_half;
    if (blink_half == '0) blink_lim = {{(BLINK_W-1){1'b0}}, 1'b1};
  end

  // Shared blink timer; >= compare lets a lowered half-period wrap on the next tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_timer <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_timer >= blink_lim - 1'b1) begin
        blink_timer <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_timer <= blink_timer + 1'b1;
      end
    end
  end

  // Triangular breath ramp; each endpoint is visited for exactly one tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      breath_lvl <= '0;
      breath_up  <= 1'b1;
    end else if (tick) begin
      if (breath_up) begin
        breath_lvl <= breath_lvl + 1'b1;
        if (breath_lvl == PWM_MAX - 1'b1) breath_up <= 1'b0;
      end else begin
        breath_lvl <= breath_lvl - 1'b1;
        if (breath_lvl == {{(PWM_BITS-1){1'b0}}, 1'b1}) breath_up <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic ch_raw;

    // Per-channel mode select.
    always_comb begin
      ch_raw = 1'b0;
      case (mode[2*i +: 2])
        MODE_OFF:     ch_raw = 1'b0;
        MODE_ON:      ch_raw = pwm_on(level, pwm_cnt);
        MODE_BLINK:   ch_raw = blink_phase & pwm_on(level, pwm_cnt);
        MODE_BREATHE: ch_raw = pwm_on(breath_lvl, pwm_cnt);
        default:      ch_raw = 1'b0;
      endcase
    end

    assign raw[i] = ch_raw;
  end

  // Register the pins with board polarity applied.
  always_ff @(posedge clk) begin
    if (!rst_n) led <= {CHANNELS{POL}};
    else        led <= raw ^ {CHANNELS{POL}};
  end

endmodule
